// File: rtl/qs_pkg.sv
// Shared types for the quicksort bank scoreboard and the sorted-stream unloader.
package qs_pkg;

  localparam int W  = 8;  // data width
  localparam int N  = 8;  // entries per bank
  localparam int NB = 4;  // number of banks

  typedef logic [W-1:0]          w_t;
  typedef logic [$clog2(N)-1:0]  addr_t;
  typedef logic [$clog2(NB)-1:0] bank_id_t;

  typedef enum logic [2:0] {
    BANK_IDLE,
    BANK_LOADING,
    BANK_READY,
    BANK_SORTING,
    BANK_SORTED,
    BANK_UNLOADING
  } bank_status_e;

  typedef struct packed {
    bank_status_e status;
    addr_t        n;
    logic         err;
  } bank_state_t;

  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
    w_t   dat;
  } beat_t;

  function automatic bank_id_t bank_id_inc(input bank_id_t id);
    return (id == bank_id_t'(NB - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/qs_deq_buf.sv
// Valid/ready output FIFO of OUT_DEPTH beats; the registered output stage counts
// as one entry, the remaining OUT_DEPTH-1 live in a circular buffer behind it.
module qs_deq_buf
  import qs_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_vld,
  input  beat_t in_beat,
  output logic  in_rdy,
  output logic  out_vld_r,
  output logic  out_sop_r,
  output logic  out_eop_r,
  output logic  out_err_r,
  output w_t    out_dat_r,
  input  logic  out_rdy
);

  localparam int MEM_D = OUT_DEPTH - 1;
  localparam int PW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;
  localparam int CW    = $clog2(OUT_DEPTH + 1);

  beat_t         mem [MEM_D];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          pop, load_out, mem_empty, take_mem, take_in, mem_wr;
  beat_t         head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MEM_D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop       = out_vld_r & out_rdy;
  assign load_out  = ~out_vld_r | pop;
  assign mem_empty = (cnt == '0);
  assign take_mem  = load_out & ~mem_empty;
  // An empty buffer lets incoming beats bypass straight into the output stage.
  assign take_in   = load_out & mem_empty & in_vld;
  assign mem_wr    = in_vld & ~take_in;
  assign in_rdy    = (cnt != CW'(MEM_D)) | load_out;
  assign head      = mem_empty ? in_beat : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_r <= 1'b0;
      out_sop_r <= 1'b0;
      out_eop_r <= 1'b0;
      out_err_r <= 1'b0;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (load_out) begin
        out_vld_r <= ~mem_empty | in_vld;
        if (take_mem | take_in) begin
          out_sop_r <= head.sop;
          out_eop_r <= head.eop;
          out_err_r <= head.err;
        end
      end
      if (mem_wr)   wr_ptr <= ptr_inc(wr_ptr);
      if (take_mem) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(mem_wr) - CW'(take_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr)                mem[wr_ptr] <= in_beat;
    if (take_mem | take_in)    out_dat_r   <= head.dat;
  end

endmodule

// File: rtl/qs_deq.sv
// Unloads a SORTED bank as a sop/eop framed stream with credit-based read issue.
// Optional QS_DEQ_ERR_EN adds out_err_r carrying the bank's latched err flag.
module qs_deq
  import qs_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output bank_id_t    bank_idx_r,
  input  bank_state_t bank_in,
  output logic        bank_out_vld,
  output bank_state_t bank_out,
  output logic        rd_en_r,
  output addr_t       rd_addr_r,
  input  w_t          rd_data,
  output logic        out_vld_r,
  output logic        out_sop_r,
  output logic        out_eop_r,
  output w_t          out_dat_r,
  input  logic        out_rdy
`ifdef QS_DEQ_ERR_EN
  ,
  output logic        out_err_r
`endif
);

  typedef enum logic [1:0] {IDLE, UNLOAD, DRAIN} state_e;

  localparam int CRW = $clog2(OUT_DEPTH + 1);

  state_e         state, state_n;
  logic [CRW-1:0] credits;
  addr_t          next_addr, n_lat, issue_addr, n_src;
  logic           err_lat, issue, latch, advance, pop, eop_pop, can_issue;
  logic           rd_sop_r, rd_eop_r;
  logic           vld_p1, sop_p1, eop_p1;
  beat_t          push_beat;
  logic           buf_rdy, buf_err, unused_sink;

  assign pop       = out_vld_r & out_rdy;
  assign eop_pop   = pop & out_eop_r;
  // Credits count free buffer slots net of reads still in flight; a pop this
  // cycle frees a slot in time for a read issued in the same cycle.
  assign can_issue = (credits != '0) | pop;
  assign n_src     = latch ? bank_in.n : n_lat;

  always_comb begin
    state_n      = state;
    issue        = 1'b0;
    issue_addr   = next_addr;
    latch        = 1'b0;
    advance      = 1'b0;
    bank_out     = bank_in;
    bank_out_vld = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bank_in.status == BANK_SORTED) begin
            bank_out_vld    = 1'b1;
            bank_out.status = BANK_UNLOADING;
            issue           = 1'b1;
            issue_addr      = '0;
            latch           = 1'b1;
            state_n         = UNLOAD;
          end
        end
        UNLOAD: begin
          if (n_lat == '0) begin
            state_n = DRAIN;
          end else if (can_issue) begin
            issue = 1'b1;
            if (next_addr == n_lat) state_n = DRAIN;
          end
        end
        DRAIN: begin
          if (eop_pop) begin
            bank_out_vld    = 1'b1;
            bank_out.status = BANK_IDLE;
            advance         = 1'b1;
            state_n         = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // p0: read issue and control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bank_idx_r <= '0;
      credits    <= CRW'(OUT_DEPTH);
      next_addr  <= '0;
      n_lat      <= '0;
      err_lat    <= 1'b0;
      rd_en_r    <= 1'b0;
      rd_addr_r  <= '0;
      vld_p1     <= 1'b0;
    end else begin
      state   <= state_n;
      credits <= credits - CRW'(issue) + CRW'(pop);
      rd_en_r <= issue;
      vld_p1  <= rd_en_r;
      if (advance) bank_idx_r <= bank_id_inc(bank_idx_r);
      if (issue) begin
        rd_addr_r <= issue_addr;
        next_addr <= issue_addr + 1'b1;
      end
      if (latch) begin
        n_lat <= bank_in.n;
`ifdef QS_DEQ_ERR_EN
        err_lat <= bank_in.err;
`else
        err_lat <= 1'b0;
`endif
      end
    end
  end

  // p1: framing flags travel with the read so they line up with rd_data
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_sop_r <= (issue_addr == '0);
      rd_eop_r <= (issue_addr == n_src);
    end
    sop_p1 <= rd_sop_r;
    eop_p1 <= rd_eop_r;
  end

  assign push_beat = {sop_p1, eop_p1, err_lat, rd_data};

  qs_deq_buf #(.OUT_DEPTH(OUT_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (vld_p1),
    .in_beat   (push_beat),
    .in_rdy    (buf_rdy),
    .out_vld_r (out_vld_r),
    .out_sop_r (out_sop_r),
    .out_eop_r (out_eop_r),
    .out_err_r (buf_err),
    .out_dat_r (out_dat_r),
    .out_rdy   (out_rdy)
  );

`ifdef QS_DEQ_ERR_EN
  assign out_err_r   = buf_err;
  assign unused_sink = buf_rdy;
`else
  assign unused_sink = ^{buf_rdy, buf_err};
`endif

endmodule

// File: tb/tb_qs_deq.sv
// Randomized scoreboard bench for qs_deq: bank table, memory and beat-queue model.
module tb_qs_deq;
  import qs_pkg::*;

  localparam int OUT_DEPTH = 4;
`ifdef QS_DEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bank_id_t    bank_idx_r;
  bank_state_t bank_in;
  logic        bank_out_vld;
  bank_state_t bank_out;
  logic        rd_en_r;
  addr_t       rd_addr_r;
  w_t          rd_data;
  logic        out_vld_r, out_sop_r, out_eop_r;
  w_t          out_dat_r;
  logic        out_rdy;
  logic        act_err;
`ifdef QS_DEQ_ERR_EN
  logic        out_err_r;
  assign act_err = out_err_r;
`else
  assign act_err = 1'b0;
`endif

  qs_deq #(.OUT_DEPTH(OUT_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bank_idx_r   (bank_idx_r),
    .bank_in      (bank_in),
    .bank_out_vld (bank_out_vld),
    .bank_out     (bank_out),
    .rd_en_r      (rd_en_r),
    .rd_addr_r    (rd_addr_r),
    .rd_data      (rd_data),
    .out_vld_r    (out_vld_r),
    .out_sop_r    (out_sop_r),
    .out_eop_r    (out_eop_r),
    .out_dat_r    (out_dat_r),
    .out_rdy      (out_rdy)
`ifdef QS_DEQ_ERR_EN
    ,
    .out_err_r    (out_err_r)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bank scoreboard and memory models
  bank_state_t bank_tab [NB];
  w_t          mem_tab [NB][N];
  int          req_seq = 0, done_seq = 0;
  bank_id_t    req_bank;
  addr_t       req_n;
  logic        req_err;

  assign bank_in = bank_tab[bank_idx_r];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) bank_tab[i] <= '{BANK_IDLE, '0, 1'b0};
    end else begin
      if (bank_out_vld) bank_tab[bank_idx_r] <= bank_out;
      if (req_seq != done_seq) begin
        bank_tab[req_bank] <= '{BANK_SORTED, req_n, req_err};
        done_seq <= req_seq;
      end
    end
  end

  always @(posedge clk) if (rd_en_r) rd_data <= mem_tab[bank_idx_r][rd_addr_r];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  int rdy_mode = 0;
  int ph = 0;
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: begin
          out_rdy = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  beat_t exp_q[$];
  beat_t exp_b, act_b;
  int    cur_n = 0;
  int    iss = 0, pops = 0, got_cnt = 0, unl_cnt = 0, idle_cnt = 0, bubbles = 0, t0 = 0;
  bit    lat_arm = 0, prev_vld = 0, prev_rdy = 0, prev_xfer = 0, have_prev = 0;
  beat_t prev_b;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      iss = 0;
      pops = 0;
      have_prev = 0;
      prev_xfer = 0;
      lat_arm = 0;
      chk("rst_bank_out_vld", bank_out_vld, 0);
    end else begin
      act_b = '{sop: out_sop_r, eop: out_eop_r, err: act_err, dat: out_dat_r};
      if (!bank_out_vld) begin
        chk("bank_passthru", bank_out, bank_in);
      end else if (bank_out.status == BANK_UNLOADING) begin
        chk("bank_was_sorted", bank_in.status, BANK_SORTED);
        unl_cnt++;
        lat_arm = 1;
        t0 = cyc;
      end else begin
        chk("bank_done_status", bank_out.status, BANK_IDLE);
        chk("bank_done_on_eop", {out_vld_r, out_rdy, out_eop_r}, 3'b111);
        idle_cnt++;
      end
      if (lat_arm && out_vld_r) begin
        chk("first_beat_latency", cyc - t0, 3);
        lat_arm = 0;
      end
      if (have_prev && prev_vld && !prev_rdy)
        chk("stall_hold", {out_vld_r, act_b}, {1'b1, prev_b});
      if (rd_en_r) begin
        iss++;
        chk("credit_limit", (iss - pops) <= OUT_DEPTH, 1);
        chk("rd_addr_max", rd_addr_r <= cur_n, 1);
      end
      if (out_vld_r && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", act_b, 0);
        end else begin
          exp_b = exp_q.pop_front();
          chk("beat", act_b, exp_b);
          if (!exp_b.sop && !prev_xfer) bubbles++;
        end
        pops++;
        got_cnt++;
      end
      prev_xfer = out_vld_r && out_rdy;
      prev_vld  = out_vld_r;
      prev_rdy  = out_rdy;
      prev_b    = act_b;
      have_prev = 1;
    end
  end

  // Stimulus
  w_t pkt_dat [N];
  int exp_idx = 0;

  task automatic start_pkt(input int n, input logic err);
    for (int i = 0; i <= n; i++) begin
      mem_tab[exp_idx][i] = pkt_dat[i];
      exp_q.push_back('{sop: (i == 0), eop: (i == n), err: ERR_EN ? err : 1'b0, dat: pkt_dat[i]});
    end
    cur_n    = n;
    req_bank = bank_id_t'(exp_idx);
    req_n    = addr_t'(n);
    req_err  = err;
    req_seq++;
  endtask

  task automatic finish_pkt(input string name);
    int k = 0;
    int b = exp_idx;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) chk({name, "_timeout"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    exp_idx = (b + 1) % NB;
    chk({name, "_bank_idx"}, bank_idx_r, exp_idx);
    chk({name, "_bank_status"}, bank_tab[b].status, BANK_IDLE);
  endtask

  task automatic run_pkt(input string name, input int n, input logic err, input int mode);
    int u0 = unl_cnt;
    int i0 = idle_cnt;
    int b0 = bubbles;
    rdy_mode = mode;
    start_pkt(n, err);
    finish_pkt(name);
    chk({name, "_unloading_seen"}, unl_cnt - u0, 1);
    chk({name, "_idle_seen"}, idle_cnt - i0, 1);
    if (mode == 0) chk({name, "_no_bubbles"}, bubbles - b0, 0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_out"}, {out_vld_r, out_sop_r, out_eop_r, rd_en_r, bank_out_vld}, 0);
    chk({name, "_addr_idx"}, {rd_addr_r, bank_idx_r}, 0);
`ifdef QS_DEQ_ERR_EN
    chk({name, "_err"}, out_err_r, 0);
`endif
  endtask

  initial begin
    int k;
    int g0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    pkt_dat[0] = 8'd4; pkt_dat[1] = 8'd7; pkt_dat[2] = 8'd9; pkt_dat[3] = 8'd12;
    run_pkt("basic_n3", 3, 1'b0, 0);

    pkt_dat[0] = 8'h55;
    run_pkt("single_n0", 0, 1'b0, 0);

    for (int i = 0; i < N; i++) pkt_dat[i] = w_t'($urandom);
    run_pkt("stall_n7", 7, 1'b0, 1);

    for (int i = 0; i < 3; i++) pkt_dat[i] = w_t'($urandom);
    run_pkt("err_n2_wrap", 2, 1'b1, 0);

    // Bank 0 again: abandon mid-packet with reset, then re-send in full
    for (int i = 0; i < 6; i++) pkt_dat[i] = w_t'($urandom);
    rdy_mode = 0;
    g0 = got_cnt;
    start_pkt(5, 1'b0);
    k = 0;
    while ((got_cnt - g0) < 2 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (k >= 200) chk("midrst_wait_timeout", got_cnt - g0, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_idx = 0;
    @(posedge clk);
    #1;
    run_pkt("resend_n5", 5, 1'b0, 0);

    run_pkt("noerr_n2", 2, 1'b0, 0);

    for (int p = 0; p < 8; p++) begin
      int n = $urandom_range(0, N - 1);
      for (int i = 0; i <= n; i++) pkt_dat[i] = w_t'($urandom);
      run_pkt("random", n, 1'($urandom_range(0, 1)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
